pulse_player: RTL

Transmit-side counterpart of the RC pulse-capture buffer. Accepts 32-bit pulse words (`{level, duration}`, same format the capture path produces) from the AXI register logic, queues them in an internal FIFO, and replays them on a single output pin with cycle-exact segment lengths. It is used to drive servo/ESC PWM or to loop back captured RC frames.

---
 rtl/pulse_player.sv | 108 ++++++++++
 1 files changed

// File: rtl/pulse_player.sv
// pulse_player: FIFO-fed replay of {level, duration} pulse words on one pin.
// Segments are cycle-exact and back-to-back while words are queued.
module pulse_player #(
   parameter int unsigned DEPTH      = 16,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              pulse_data,
   input  logic                     wr,
   output logic                     rdy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     pulse_out,
   output logic                     busy,
   output logic                     underrun,
   output logic                     wr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_PLAY = 1'b1;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [0:0]    state;
   logic [30:0]   cnt;
   logic          push;
   logic          pop;
   logic          empty;
   logic          seg_end;
   logic [31:0]   head;
   logic [30:0]   head_dur;

   assign rdy      = fifo_count < FULL;
   assign empty    = fifo_count == '0;
   assign push     = wr & rdy;
   assign busy     = state == S_PLAY;
   assign seg_end  = busy && (cnt == 31'd1);
   assign pop      = !empty && (state == S_IDLE || seg_end);
   assign head     = mem[rd_ptr];
   // zero-length words still occupy one cycle
   assign head_dur = (head[30:0] == '0) ? 31'd1 : head[30:0];

   // storage is left unreset so it can map onto block RAM
   always_ff @(posedge clk) begin
      if (reset && push) begin
         mem[wr_ptr] <= pulse_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         state      <= S_IDLE;
         cnt        <= '0;
         pulse_out  <= IDLE_LEVEL;
         underrun   <= 1'b0;
         wr_err     <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end

         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase

         wr_err   <= wr & ~rdy;
         underrun <= seg_end & empty;

         unique case (state)
            S_IDLE: begin
               if (pop) begin
                  pulse_out <= head[31];
                  cnt       <= head_dur;
                  state     <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (pop) begin
                  pulse_out <= head[31];
                  cnt       <= head_dur;
               end else if (seg_end) begin
                  state <= S_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - 31'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
